// File: rtl/wb_stage.sv
// Write-back stage: one-entry pipeline register, register-file commit,
// machine CSR file, ecall/mret redirect and ebreak halt.
module wb_stage #(
    parameter int unsigned XLEN = 64,
    parameter logic [XLEN-1:0] MSTATUS_RST = 64'h0000000a00001800
) (
    input  logic            clock,
    input  logic            reset,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [XLEN-1:0] in_pc,
    input  logic [31:0]     in_inst,
    input  logic [XLEN-1:0] in_nextpc,
    input  logic            in_wen,
    input  logic [4:0]      in_waddr,
    input  logic            in_readflag,
    input  logic [XLEN-1:0] in_alures,
    input  logic [XLEN-1:0] in_lsures,
    input  logic            in_csrflag,
    input  logic [2:0]      in_func3,
    input  logic            in_ecall,
    input  logic            in_mret,
    input  logic            in_ebreak,
    input  logic            in_abort,
    input  logic            in_skipref,
    output logic            rf_wen,
    output logic [4:0]      rf_waddr,
    output logic [XLEN-1:0] rf_wdata,
    output logic            redirect_valid,
    output logic [XLEN-1:0] redirect_pc,
    output logic            commit_valid,
    output logic [XLEN-1:0] commit_pc,
    output logic [31:0]     commit_inst,
    output logic [XLEN-1:0] commit_nextpc,
    output logic            commit_skipref,
    output logic            halt
);

    typedef enum logic {RUN, HALT} state_t;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [31:0]     inst;
        logic [XLEN-1:0] nextpc;
        logic            wen;
        logic [4:0]      waddr;
        logic            readflag;
        logic [XLEN-1:0] alures;
        logic [XLEN-1:0] lsures;
        logic            csrflag;
        logic [2:0]      func3;
        logic            ecall;
        logic            mret;
        logic            ebreak;
        logic            abort;
        logic            skipref;
    } entry_t;

    state_t          state, state_next;
    entry_t          entry;
    logic            entry_valid;
    logic [XLEN-1:0] mstatus, mtvec, mepc, mcause;

    logic            live;
    logic            do_ebreak, do_ecall, do_mret, do_csr;
    logic [11:0]     csr_addr;
    logic [XLEN-1:0] csr_old, csr_new;
    logic            csr_we;
    logic [XLEN-1:0] mstatus_trap, mstatus_ret;

    assign live      = entry_valid && !entry.abort;
    assign do_ebreak = live && entry.ebreak;
    assign do_ecall  = live && entry.ecall && !entry.ebreak;
    assign do_mret   = live && entry.mret && !entry.ebreak && !entry.ecall;
    assign do_csr    = live && entry.csrflag && !entry.ebreak
                     && !entry.ecall && !entry.mret;
    assign csr_addr  = entry.inst[31:20];

    always_comb begin
        csr_old = '0;
        unique case (csr_addr)
            12'h300: csr_old = mstatus;
            12'h305: csr_old = mtvec;
            12'h341: csr_old = mepc;
            12'h342: csr_old = mcause;
            default: csr_old = '0;
        endcase
    end

    always_comb begin
        csr_new = csr_old;
        csr_we  = 1'b0;
        unique case (entry.func3[1:0])
            2'b01: begin csr_new = entry.alures;            csr_we = 1'b1; end
            2'b10: begin csr_new = csr_old | entry.alures;  csr_we = 1'b1; end
            2'b11: begin csr_new = csr_old & ~entry.alures; csr_we = 1'b1; end
            default: ;
        endcase
    end

    always_comb begin
        mstatus_trap        = mstatus;
        mstatus_trap[7]     = mstatus[3];
        mstatus_trap[3]     = 1'b0;
        mstatus_trap[12:11] = 2'b11;
        mstatus_ret         = mstatus;
        mstatus_ret[3]      = mstatus[7];
        mstatus_ret[7]      = 1'b1;
    end

    always_comb begin
        state_next = state;
        unique case (state)
            RUN:     if (do_ebreak) state_next = HALT;
            HALT:    state_next = HALT;
            default: state_next = RUN;
        endcase
    end

    assign in_ready       = (state == RUN) && !reset;
    assign halt           = (state == HALT);
    assign commit_valid   = live;
    assign commit_pc      = entry.pc;
    assign commit_inst    = entry.inst;
    assign commit_nextpc  = entry.nextpc;
    assign commit_skipref = entry.skipref;
    assign rf_wen         = live && entry.wen && (entry.waddr != 5'd0)
                          && !entry.ebreak;
    assign rf_waddr       = entry.waddr;
    assign rf_wdata       = entry.csrflag  ? csr_old :
                            entry.readflag ? entry.lsures : entry.alures;
    assign redirect_valid = do_ecall || do_mret;
    assign redirect_pc    = do_ecall ? mtvec : do_mret ? mepc : '0;

    always_ff @(posedge clock) begin
        if (reset) begin
            state       <= RUN;
            entry_valid <= 1'b0;
            entry       <= '0;
            mstatus     <= MSTATUS_RST;
            mtvec       <= '0;
            mepc        <= '0;
            mcause      <= '0;
        end else begin
            state <= state_next;
            if (state == RUN && state_next == RUN) begin
                entry <= '{pc: in_pc, inst: in_inst, nextpc: in_nextpc,
                           wen: in_wen, waddr: in_waddr,
                           readflag: in_readflag, alures: in_alures,
                           lsures: in_lsures, csrflag: in_csrflag,
                           func3: in_func3, ecall: in_ecall,
                           mret: in_mret, ebreak: in_ebreak,
                           abort: in_abort, skipref: in_skipref};
                // Anything accepted alongside a redirect is wrong-path.
                entry_valid <= in_valid && !redirect_valid;
            end else begin
                entry_valid <= 1'b0;
            end
            if (do_csr && csr_we) begin
                unique case (csr_addr)
                    12'h300: mstatus <= csr_new;
                    12'h305: mtvec   <= csr_new;
                    12'h341: mepc    <= csr_new;
                    12'h342: mcause  <= csr_new;
                    default: ;
                endcase
            end
            if (do_ecall) begin
                mepc    <= entry.pc;
                mcause  <= 64'd11;
                mstatus <= mstatus_trap;
            end
            if (do_mret) mstatus <= mstatus_ret;
        end
    end

endmodule

// File: doc/wb_stage.md
Name: wb_stage

Overview:
- Write-back stage of the RV64 in-order pipeline, directly downstream of the load/store stage.
- Consumes the LS→WB bundle through a valid/ready handshake and holds it in a one-entry pipeline register.
- Commits the entry: register-file write, machine CSR file (mstatus/mtvec/mepc/mcause), ecall/mret redirect, ebreak halt.
- Exports per-instruction commit info for difftest.

Parameters:
- XLEN, 64, datapath width.
- MSTATUS_RST, 64'h0000000a00001800, mstatus reset value.

Ports:
- clock  in  1  clock
- reset  in  1  synchronous active-high reset
- in_valid  in  1  LS stage has an instruction
- in_ready  out  1  stage accepts this cycle
- in_pc  in  64  instruction PC
- in_inst  in  32  instruction word; CSR address = inst[31:20]
- in_nextpc  in  64  sequential/branch next PC
- in_wen  in  1  writes rd
- in_waddr  in  5  rd
- in_readflag  in  1  load; rd data from lsures
- in_alures  in  64  ALU result; for CSR ops, source operand (rs1 value or zero-extended zimm, selected in EX)
- in_lsures  in  64  sign/zero-extended load data
- in_csrflag  in  1  Zicsr instruction
- in_func3  in  3  CSR op select
- in_ecall, in_mret, in_ebreak, in_abort, in_skipref  in  1 each  flags
- rf_wen  out  1  register-file write enable
- rf_waddr  out  5  register-file write address
- rf_wdata  out  64  register-file write data
- redirect_valid  out  1  PC redirect / front-end flush
- redirect_pc  out  64  redirect target
- commit_valid  out  1  instruction retires this cycle
- commit_pc  out  64  retiring PC
- commit_inst  out  32  retiring instruction word
- commit_nextpc  out  64  retiring next PC
- commit_skipref  out  1  difftest skip flag
- halt  out  1  core halted by ebreak

Behaviour:
- Reset:
  - entry_valid=0, state=RUN.
  - mstatus=MSTATUS_RST; mtvec, mepc, mcause = 0.
  - All outputs 0, except in_ready=1 in the cycle after reset deasserts.
  - Reset mid-operation discards the held entry; no write or redirect is emitted.
- States:
  - RUN: in_ready=1.
  - HALT: in_ready=0, halt=1, entry_valid forced 0. Left only by reset.
- Capture, RUN:
  - Every cycle: entry <= bundle, entry_valid <= in_valid && !redirect_valid.
  - An instruction accepted in the same cycle a redirect is emitted is squashed (it is wrong-path).
- Commit timing:
  - Latency 1: accepted at edge N, outputs valid throughout cycle N+1.
  - CSR/state updates take effect at edge N+1.
  - Back-to-back accept sustains 1 instruction per cycle.
- live = entry_valid && !entry.abort.
  - An aborted entry produces no rf write, CSR change, redirect, commit or halt.
- commit_valid=live; commit_pc/inst/nextpc/skipref driven from the entry.
- Register-file write:
  - rf_wen = live && wen && waddr!=0; rf_waddr = waddr.
  - rf_wdata = csrflag ? old CSR value : readflag ? lsures : alures.
- CSR addresses: mstatus 0x300, mtvec 0x305, mepc 0x341, mcause 0x342.
  - Unknown address reads 0; writes to it are ignored.
- CSR ops on live && csrflag, with src=alures and old=current CSR value:
  - func3 001/101: new = src.
  - func3 010/110: new = old | src.
  - func3 011/111: new = old & ~src.
  - Other func3: no write.
- A CSR op is seen by the next committed instruction; back-to-back CSR ops read the updated value.
- ecall (live):
  - mepc <= pc, mcause <= 11.
  - mstatus.MPIE(7) <= MIE(3), MIE <= 0, MPP(12:11) <= 2'b11.
  - redirect_valid=1, redirect_pc=mtvec (value before this edge).
- mret (live):
  - redirect_valid=1, redirect_pc=mepc.
  - MIE <= MPIE, MPIE <= 1.
- ebreak (live): commit_valid=1; state <= HALT at the commit edge; rd not written.
- redirect_valid is asserted only for ecall/mret and only in the commit cycle. Other branches are resolved upstream.
- Simultaneous flags: priority ebreak > ecall > mret > csr.
- in_valid=0 in RUN: entry_valid clears next cycle; no outputs asserted.

Test Plan:
- Load commit: accept pc=0x80000000, readflag=1, wen=1, waddr=5, lsures=0xffffffffffffff80 -> next cycle rf_wen=1, rf_waddr=5, rf_wdata=0xffffffffffffff80, commit_valid=1.
- x0 / abort: wen=1, waddr=0, alures=7 -> rf_wen=0, commit_valid=1. Same with abort=1 -> commit_valid=0, rf_wen=0.
- CSR sequence:
  - csrrw mtvec (inst[31:20]=0x305, func3=001, alures=0x80001000) -> next commit.
  - csrrs mtvec with src 0xf -> rf_wdata=0x80001000; mtvec becomes 0x8000100f.
- ecall at pc 0x80000040, mtvec=0x80001000:
  - redirect_valid=1, redirect_pc=0x80001000.
  - Afterwards mepc=0x80000040, mcause=11, mstatus.MIE=0, MPP=3.
  - An in_valid instruction offered that cycle is not committed.
- mret after ecall: redirect_pc=0x80000040; mstatus.MIE restored from MPIE; MPIE=1.
- ebreak then further in_valid: halt=1 from the cycle after commit; in_ready=0; no further commit_valid. Reset -> halt=0, in_ready=1, mstatus=0xa00001800.
